program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time loader upstream of the CPU core: accepts a byte stream (valid/ready), packs bytes into
//  32-bit instruction words and writes them sequentially into instruction memory from address 0.
//  Holds the core stalled via cpu_hold until a complete, checksum-verified image is in memory.
//  cpu_hold drives the core's halt/stall input. Releasing it lets the core start fetching at PC 0.
// PARAMETERS
//  ADDR_W     10    instruction-memory word-address width
//  DATA_W     32    instruction word width; fixed at 4 bytes
//  MAX_WORDS  1024  largest accepted image in words; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       system clock; all state updates on rising edge
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       one-cycle pulse: begin a new load; ignored unless state is IDLE, DONE or ERROR
//  byte_valid  in   1       upstream byte present on byte_data
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts byte_data this cycle; transfer = byte_valid & byte_ready
//  imem_we     out  1       instruction-memory write strobe, one cycle per word
//  imem_addr   out  ADDR_W  word address for the write
//  imem_wdata  out  DATA_W  word to write
//  cpu_hold    out  1       1 = core stalled; 0 only in DONE
//  load_done   out  1       level: image loaded and verified
//  load_err    out  1       level: length or checksum error
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; cpu_hold=1; byte_ready=0; imem_we=0; imem_addr=0;
//   imem_wdata=0; load_done=0; load_err=0. All counters, checksum and packer cleared.
//   Reset mid-load aborts the load. Words already written stay in memory.
//  Stream format: LEN_LO, LEN_HI (N = 16-bit word count), then N*4 payload bytes, little-endian per word
//   (first byte -> bits[7:0]), then one CHK byte = XOR of all payload bytes. CHK is 0x00 when N=0.
//  FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
//   IDLE/DONE/ERROR --start--> LEN_LO. On this transition load_done=0, load_err=0, cpu_hold=1,
//    imem_addr=0 and the checksum is cleared.
//   LEN_LO --xfer--> LEN_HI.
//   LEN_HI --xfer--> one of:
//    ERROR if N > MAX_WORDS;
//    CHECK if N == 0;
//    DATA otherwise.
//   DATA: each transfer XORs the byte into the checksum and shifts it into the packer.
//    On the 4th byte of a word: imem_wdata <= packed word, and imem_we=1 on the next cycle for exactly
//    one cycle at the current imem_addr. imem_addr then increments on the cycle after the strobe.
//    After word N is accepted -> CHECK.
//   CHECK --xfer--> DONE if byte == checksum, else ERROR.
//   DONE: cpu_hold=0, load_done=1.
//   ERROR: cpu_hold=1, load_err=1.
//  byte_ready=1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in IDLE, DONE and ERROR.
//   Full throughput of 1 byte/clk; no back-pressure is needed because the write register is single-entry.
//  byte_valid=0 in any state: the loader holds its state; there is no timeout.
//  start during LEN_LO..CHECK is ignored. start in the same cycle as a transfer in a terminal state:
//   start wins and the byte is not consumed (byte_ready=0).
//  Address wrap: cannot occur, since N <= MAX_WORDS <= 2**ADDR_W. The last write is at N-1.
//  Checksum is 8-bit XOR, width-exact. N is held in a 16-bit register and compared before any write.
// STRUCTURE
//  Shared defines file (`include): FSM state encodings (3-bit), WORD_BYTES=4, checksum seed 8'h00.
//  One sub-module: byte_packer — 2-bit byte index, shift register, word_ready pulse on the 4th byte,
//   synchronous clear on start.
//  Top level holds the FSM, word counter, address register, checksum and output registers.
// TESTING
//  1 Reset with rst=0 then 1, no start -> cpu_hold=1, byte_ready=0, imem_we never asserted, load_done=0.
//  2 start; stream 02 00 | 13 00 00 00 | 0A 21 00 00 | 38 (CHK = 13^0A^21 = 38)
//     -> writes addr0=0x00000013, addr1=0x0000210A; load_done=1; cpu_hold=0 on the cycle after CHK.
//  3 Same stream with CHK=0x39 -> no change to the two writes; load_err=1; cpu_hold stays 1;
//     a fresh start clears load_err.
//  4 LEN = 0x0401 (1025 > MAX_WORDS) -> ERROR right after LEN_HI, zero writes;
//     LEN = 00 00 followed by CHK 00 -> DONE with zero writes.
//  5 Gaps: drop byte_valid for 5 cycles between each payload byte -> identical memory contents and
//     timing relative to transfers.
//  6 Assert rst low mid-DATA (after 6 bytes) -> outputs return to reset values within the same cycle;
//     after release, a full load from start completes correctly.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// word geometry and checksum seed.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [7:0] CHK_SEED   = 8'h00;

    // A new load may only be started from a resting state.
    function automatic logic is_terminal(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Collects four stream bytes little-endian into one instruction word.
// word_ready_o pulses combinationally with the transfer of the 4th byte,
// while word_o already presents the completed word.
module program_loader_byte_packer
    import program_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              xfer_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_ready_o
);

    localparam int SH_W = DATA_W - 8;

    logic [1:0]      idx_q;
    logic [SH_W-1:0] sh_q;

    // Newest byte enters at the top, so the first byte ends up in bits [7:0].
    assign word_o       = {byte_i, sh_q};
    assign word_ready_o = xfer_i && (idx_q == 2'(WORD_BYTES - 1));

    // Byte index and shift register; cleared when a new load starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else if (clear_i) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else if (xfer_i) begin
            idx_q <= idx_q + 2'd1;
            sh_q  <= {byte_i, sh_q[SH_W-1:8]};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives LEN_LO, LEN_HI, N*4 payload bytes and an XOR
// checksum byte, writes the words to instruction memory from address 0
// and keeps the core stalled until the image is verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [15:0]       wcnt_q;
    logic [7:0]        chk_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              xfer;
    logic              start_go;
    logic [15:0]       n_full;
    logic              data_xfer;
    logic              word_ready;
    logic [DATA_W-1:0] word;
    logic              last_word;

    assign xfer      = byte_valid && byte_ready;
    assign start_go  = start && is_terminal(state_q);
    assign n_full    = {byte_data, len_lo_q};
    assign data_xfer = xfer && (state_q == ST_DATA);
    assign last_word = word_ready && (wcnt_q == (len_q - 16'd1));

    program_loader_byte_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_go),
        .xfer_i      (data_xfer),
        .byte_i      (byte_data),
        .word_o      (word),
        .word_ready_o(word_ready)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic; the length is range-checked before any write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if (n_full > MAX_N)       state_d = ST_ERROR;
                    else if (n_full == 16'd0) state_d = ST_CHECK;
                    else                      state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_word) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (xfer) state_d = (byte_data == chk_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: all status levels decode directly from the state register.
    always_comb begin
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (state_q)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: byte_ready = 1'b1;
            ST_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            ST_ERROR: load_err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, checksum, word count and the single-entry
    // write register. The address advances on the cycle after each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_q <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            chk_q    <= CHK_SEED;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (we_q) addr_q <= addr_q + 1'b1;
            if (start_go) begin
                addr_q <= '0;
                chk_q  <= CHK_SEED;
                wcnt_q <= '0;
            end
            if (xfer && (state_q == ST_LEN_LO)) len_lo_q <= byte_data;
            if (xfer && (state_q == ST_LEN_HI)) len_q    <= n_full;
            if (data_xfer) chk_q <= chk_q ^ byte_data;
            if (word_ready) begin
                wdata_q <= word;
                we_q    <= 1'b1;
                wcnt_q  <= wcnt_q + 16'd1;
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule
